// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Multi-cycle fetch/execute controller. It fetches one instruction from a
//   variable-latency instruction memory, holds it in the instruction register
//   that feeds the core, and gives the core exactly one CORE_EN step per
//   executed instruction. Sequencing ends on the halt opcode, on a STOP
//   request (at the next instruction boundary), or, optionally, on a fetch
//   timeout.
//
//   Optional feature macro: FETCH_SEQ_TIMEOUT_EN
//     defined   : FETCH gives up after TIMEOUT_CYCLES+1 cycles without
//                 MEM_READY and the block parks in ERR (ERROR=1).
//     undefined : FETCH waits indefinitely; ERROR is tied to 0.
//
//   Ports
//     CLK          in   clock, all state changes on rising edge
//     RESET        in   synchronous active-low reset
//     START        in   begin sequencing from IDLE
//     STOP         in   stop at the next instruction boundary
//     PC           in   current PC from the core
//     MEM_REQ      out  fetch request (high in FETCH)
//     MEM_ADDR     out  fetch address (registered)
//     MEM_READY    in   memory response valid
//     MEM_RDATA    in   fetched instruction
//     INSTRUCTION  out  instruction register feeding the core
//     CORE_EN      out  one-cycle step enable for the core (high in EXEC)
//     BUSY         out  high in FETCH, EXEC and SETTLE
//     HALTED       out  sticky halt-opcode flag
//     ERROR        out  sticky fetch-timeout flag
//     INSTR_COUNT  out  executed-instruction count (wraps)

module fetch_sequencer #(
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned INSTR_WIDTH    = 19,
  parameter logic [3:0]  HALT_OPCODE    = 4'hF,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic                   STOP,
  input  logic [PC_WIDTH-1:0]    PC,
  output logic                   MEM_REQ,
  output logic [PC_WIDTH-1:0]    MEM_ADDR,
  input  logic                   MEM_READY,
  input  logic [INSTR_WIDTH-1:0] MEM_RDATA,
  output logic [INSTR_WIDTH-1:0] INSTRUCTION,
  output logic                   CORE_EN,
  output logic                   BUSY,
  output logic                   HALTED,
  output logic                   ERROR,
  output logic [15:0]            INSTR_COUNT
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]             state_q, state_d;
  logic                   stop_q, stop_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [15:0]            count_q, count_d;
  logic                   fetch_is_halt;
  logic                   timeout;

  assign fetch_is_halt = (MEM_RDATA[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

`ifdef FETCH_SEQ_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_LIMIT = 4'(TIMEOUT_CYCLES);

  logic [3:0] wait_q, wait_d;

  // Held at zero outside FETCH, so every entry into FETCH starts from zero.
  always_comb begin
    wait_d = wait_q;
    if (state_q != S_FETCH) begin
      wait_d = '0;
    end else if (!MEM_READY) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  // A ready in the final allowed cycle still completes the fetch.
  assign timeout = (state_q == S_FETCH) && !MEM_READY && (wait_q == TIMEOUT_LIMIT);
  assign ERROR   = (state_q == S_ERR);
`else
  assign timeout = 1'b0;
  assign ERROR   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (START && !STOP) begin
          state_d = S_FETCH;
          addr_d  = PC;
        end
      end
      S_FETCH: begin
        if (MEM_READY) begin
          instr_d = MEM_RDATA;
          state_d = fetch_is_halt ? S_HALT : S_EXEC;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_EXEC: begin
        state_d = S_SETTLE;
        count_d = count_q + 16'd1;
      end
      S_SETTLE: begin
        if (stop_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
          addr_d  = PC;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // STOP is only remembered while sequencing and is dropped on return to IDLE.
  always_comb begin
    stop_d = stop_q;
    if (state_d == S_IDLE) begin
      stop_d = 1'b0;
    end else if ((state_q != S_IDLE) && STOP) begin
      stop_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      stop_q  <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign MEM_REQ     = (state_q == S_FETCH);
  assign MEM_ADDR    = addr_q;
  assign INSTRUCTION = instr_q;
  assign CORE_EN     = (state_q == S_EXEC);
  assign BUSY        = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_SETTLE);
  assign HALTED      = (state_q == S_HALT);
  assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic        STOP;
  logic [31:0] PC;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_READY;
  logic [18:0] MEM_RDATA;
  logic [18:0] INSTRUCTION;
  logic        CORE_EN;
  logic        BUSY;
  logic        HALTED;
  logic        ERROR;
  logic [15:0] INSTR_COUNT;

  int errors = 0;
  int checks = 0;

  fetch_sequencer #(
    .PC_WIDTH(32),
    .INSTR_WIDTH(19),
    .HALT_OPCODE(4'hF),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .START(START),
    .STOP(STOP),
    .PC(PC),
    .MEM_REQ(MEM_REQ),
    .MEM_ADDR(MEM_ADDR),
    .MEM_READY(MEM_READY),
    .MEM_RDATA(MEM_RDATA),
    .INSTRUCTION(INSTRUCTION),
    .CORE_EN(CORE_EN),
    .BUSY(BUSY),
    .HALTED(HALTED),
    .ERROR(ERROR),
    .INSTR_COUNT(INSTR_COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance past the next rising edge; outputs then show the new cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    START = 1'b0;
    STOP  = 1'b0;
    MEM_READY = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (MEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", MEM_REQ); end
    checks++; if (MEM_ADDR !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", MEM_ADDR); end
    checks++; if (INSTRUCTION !== 19'h0) begin errors++; $display("FAIL reset_instruction: got %h expected 0", INSTRUCTION); end
    checks++; if (CORE_EN !== 1'b0) begin errors++; $display("FAIL reset_core_en: got %b expected 0", CORE_EN); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    checks++; if (HALTED !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", HALTED); end
    checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", ERROR); end
    checks++; if (INSTR_COUNT !== 16'h0) begin errors++; $display("FAIL reset_count: got %0d expected 0", INSTR_COUNT); end
  endtask

  task automatic test_run();
    logic exp_en;
    do_reset();
    PC = 32'h0;
    MEM_READY = 1'b1;
    MEM_RDATA = 19'h01234;
    START = 1'b1;
    tick();
    START = 1'b0;
    checks++; if (MEM_REQ !== 1'b1) begin errors++; $display("FAIL run_first_req: got %b expected 1", MEM_REQ); end
    checks++; if (MEM_ADDR !== 32'h0) begin errors++; $display("FAIL run_first_addr: got %h expected 0", MEM_ADDR); end
    for (int k = 1; k <= 12; k++) begin
      exp_en = ((k % 3) == 2);
      checks++; if (CORE_EN !== exp_en) begin errors++; $display("FAIL run_core_en_cycle%0d: got %b expected %b", k, CORE_EN, exp_en); end
      if (k == 2) begin
        checks++; if (INSTRUCTION !== 19'h01234) begin errors++; $display("FAIL run_instruction: got %h expected 01234", INSTRUCTION); end
      end
      if (k == 3) PC = 32'h0000_0010;
      if (k == 4) begin
        checks++; if (MEM_ADDR !== 32'h0000_0010) begin errors++; $display("FAIL run_reload_addr: got %h expected 00000010", MEM_ADDR); end
      end
      tick();
    end
    checks++; if (INSTR_COUNT !== 16'd4) begin errors++; $display("FAIL run_count: got %0d expected 4", INSTR_COUNT); end
  endtask

  task automatic test_wait_states();
    int pulses;
    pulses = 0;
    do_reset();
    PC = 32'h0000_0100;
    MEM_READY = 1'b0;
    MEM_RDATA = 19'h7FFFF;
    START = 1'b1;
    tick();
    START = 1'b0;
    PC = 32'h0000_0200;
    for (int c = 1; c <= 4; c++) begin
      checks++; if (MEM_REQ !== 1'b1) begin errors++; $display("FAIL wait_req_cycle%0d: got %b expected 1", c, MEM_REQ); end
      checks++; if (MEM_ADDR !== 32'h0000_0100) begin errors++; $display("FAIL wait_addr_cycle%0d: got %h expected 00000100", c, MEM_ADDR); end
      checks++; if (INSTRUCTION !== 19'h0) begin errors++; $display("FAIL wait_instr_cycle%0d: got %h expected 0", c, INSTRUCTION); end
      if (CORE_EN === 1'b1) pulses++;
      if (c == 4) begin
        MEM_READY = 1'b1;
        MEM_RDATA = 19'h05555;
      end
      tick();
    end
    MEM_READY = 1'b0;
    MEM_RDATA = 19'h0AAAA;
    checks++; if (INSTRUCTION !== 19'h05555) begin errors++; $display("FAIL wait_instr_loaded: got %h expected 05555", INSTRUCTION); end
    checks++; if (MEM_REQ !== 1'b0) begin errors++; $display("FAIL wait_req_exec: got %b expected 0", MEM_REQ); end
    for (int c = 5; c <= 7; c++) begin
      if (CORE_EN === 1'b1) pulses++;
      tick();
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL wait_core_en_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_halt();
    do_reset();
    PC = 32'h0000_0040;
    MEM_READY = 1'b1;
    MEM_RDATA = 19'h78000;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    checks++; if (HALTED !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", HALTED); end
    checks++; if (CORE_EN !== 1'b0) begin errors++; $display("FAIL halt_core_en: got %b expected 0", CORE_EN); end
    checks++; if (MEM_REQ !== 1'b0) begin errors++; $display("FAIL halt_req: got %b expected 0", MEM_REQ); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL halt_busy: got %b expected 0", BUSY); end
    START = 1'b1;
    tick();
    tick();
    START = 1'b0;
    tick();
    checks++; if (HALTED !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", HALTED); end
    checks++; if (MEM_REQ !== 1'b0) begin errors++; $display("FAIL halt_restart_req: got %b expected 0", MEM_REQ); end
    checks++; if (INSTR_COUNT !== 16'd0) begin errors++; $display("FAIL halt_count: got %0d expected 0", INSTR_COUNT); end
  endtask

  task automatic test_stop_boundary();
    do_reset();
    PC = 32'h0000_0020;
    MEM_READY = 1'b1;
    MEM_RDATA = 19'h01234;
    START = 1'b1;
    STOP = 1'b1;
    tick();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL stop_start_both: got busy %b expected 0", BUSY); end
    STOP = 1'b0;
    tick();
    START = 1'b0;
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    checks++; if (CORE_EN !== 1'b1) begin errors++; $display("FAIL stop_exec_completes: got %b expected 1", CORE_EN); end
    tick();
    checks++; if (CORE_EN !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL stop_settle: got core_en %b busy %b expected 0 1", CORE_EN, BUSY); end
    tick();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL stop_idle_busy: got %b expected 0", BUSY); end
    checks++; if (INSTR_COUNT !== 16'd1) begin errors++; $display("FAIL stop_count: got %0d expected 1", INSTR_COUNT); end
    tick();
    checks++; if (MEM_REQ !== 1'b0) begin errors++; $display("FAIL stop_stays_idle: got %b expected 0", MEM_REQ); end
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (MEM_REQ !== 1'b1) begin errors++; $display("FAIL stop_latch_cleared: got %b expected 1", MEM_REQ); end
    checks++; if (INSTR_COUNT !== 16'd2) begin errors++; $display("FAIL stop_count_rerun: got %0d expected 2", INSTR_COUNT); end
  endtask

  task automatic test_mid_fetch_reset();
    do_reset();
    PC = 32'h0000_0080;
    MEM_READY = 1'b0;
    MEM_RDATA = 19'h01234;
    START = 1'b1;
    tick();
    START = 1'b0;
    checks++; if (MEM_REQ !== 1'b1) begin errors++; $display("FAIL mrst_in_fetch: got %b expected 1", MEM_REQ); end
    RESET = 1'b0;
    START = 1'b1;
    tick();
    checks++; if (MEM_REQ !== 1'b0) begin errors++; $display("FAIL mrst_req_drop: got %b expected 0", MEM_REQ); end
    RESET = 1'b1;
    START = 1'b0;
    MEM_READY = 1'b1;
    tick();
    MEM_READY = 1'b0;
    checks++; if (MEM_REQ !== 1'b0) begin errors++; $display("FAIL mrst_req_after: got %b expected 0", MEM_REQ); end
    checks++; if (INSTRUCTION !== 19'h0) begin errors++; $display("FAIL mrst_instruction: got %h expected 0", INSTRUCTION); end
    checks++; if (INSTR_COUNT !== 16'd0) begin errors++; $display("FAIL mrst_count: got %0d expected 0", INSTR_COUNT); end
    checks++; if (MEM_ADDR !== 32'h0) begin errors++; $display("FAIL mrst_addr: got %h expected 0", MEM_ADDR); end
  endtask

  task automatic test_timeout();
    do_reset();
    PC = 32'h0000_0300;
    MEM_READY = 1'b0;
    MEM_RDATA = 19'h01234;
    START = 1'b1;
    tick();
    START = 1'b0;
`ifdef FETCH_SEQ_TIMEOUT_EN
    for (int c = 1; c <= 16; c++) begin
      checks++; if (MEM_REQ !== 1'b1 || ERROR !== 1'b0) begin errors++; $display("FAIL tmo_fetch_cycle%0d: got req %b err %b expected 1 0", c, MEM_REQ, ERROR); end
      tick();
    end
    checks++; if (ERROR !== 1'b1) begin errors++; $display("FAIL tmo_error: got %b expected 1", ERROR); end
    checks++; if (MEM_REQ !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL tmo_req: got req %b busy %b expected 0 0", MEM_REQ, BUSY); end
    do_reset();
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 16) MEM_READY = 1'b1;
      tick();
    end
    MEM_READY = 1'b0;
    checks++; if (CORE_EN !== 1'b1 || ERROR !== 1'b0) begin errors++; $display("FAIL tmo_ready_wins: got core_en %b err %b expected 1 0", CORE_EN, ERROR); end
`else
    for (int c = 1; c <= 100; c++) tick();
    checks++; if (MEM_REQ !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL notmo_still_fetch: got req %b busy %b expected 1 1", MEM_REQ, BUSY); end
    checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL notmo_error: got %b expected 0", ERROR); end
    MEM_READY = 1'b1;
    tick();
    MEM_READY = 1'b0;
    checks++; if (CORE_EN !== 1'b1) begin errors++; $display("FAIL notmo_late_ready: got %b expected 1", CORE_EN); end
`endif
  endtask

  initial begin
    RESET = 1'b0;
    START = 1'b0;
    STOP = 1'b0;
    PC = 32'h0;
    MEM_READY = 1'b0;
    MEM_RDATA = 19'h0;
    test_reset();
    test_run();
    test_wait_states();
    test_halt();
    test_stop_boundary();
    test_mid_fetch_reset();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
